// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: 2-read/1-write register file with optional write bypass and bulk-clear sequencer
module regfile_2r1w_clr #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid1,
  output logic              rd_valid2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam bit FWD = (BYPASS != 0);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
  logic rd_valid1_q, rd_valid1_d, rd_valid2_q, rd_valid2_d, busy_q, busy_d;
  always_comb begin
    regs_d = regs_q;
    state_d = state_q;
    idx_d = idx_q;
    busy_d = busy_q;
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    rd_valid1_d = 1'b0;
    rd_valid2_d = 1'b0;
    if (state_q == IDLE) begin
      if (wr_en) regs_d[wr_addr] = wr_data;
      if (rd_en1) begin
        rd_data1_d = (FWD && wr_en && wr_addr == rd_addr1) ? wr_data : regs_q[rd_addr1];
        rd_valid1_d = 1'b1;
      end
      if (rd_en2) begin
        rd_data2_d = (FWD && wr_en && wr_addr == rd_addr2) ? wr_data : regs_q[rd_addr2];
        rd_valid2_d = 1'b1;
      end
      if (clr_req) begin
        state_d = CLEAR;
        busy_d = 1'b1;
        idx_d = '0;
      end
    end else begin
      // one register per cycle; idx wraps to 0 naturally after the last entry
      regs_d[idx_q] = '0;
      idx_d = idx_q + 1'b1;
      state_d = (idx_q == '1) ? IDLE : CLEAR;
      busy_d = (idx_q != '1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      state_q <= IDLE;
      idx_q <= '0;
      busy_q <= 1'b0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid1_q <= 1'b0;
      rd_valid2_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      state_q <= state_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_valid1_q <= rd_valid1_d;
      rd_valid2_q <= rd_valid2_d;
    end
  end
  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign rd_valid1 = rd_valid1_q;
  assign rd_valid2 = rd_valid2_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb_regfile_2r1w_clr: randomized and directed checks of regfile_2r1w_clr against a behavioural model
module tb_regfile_2r1w_clr;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic rd_en1 = 0, rd_en2 = 0, wr_en = 0, clr_req = 0;
  logic [3:0] rd_addr1 = 0, rd_addr2 = 0, wr_addr = 0;
  logic [15:0] wr_data = 0;
  logic [15:0] rd_data1, rd_data2, nb_data1, nb_data2;
  logic rd_valid1, rd_valid2, busy, nb_valid1, nb_valid2, nb_busy;
  regfile_2r1w_clr dut (
    .clk(clk), .rst_n(rst_n), .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2),
    .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_valid1(rd_valid1),
    .rd_valid2(rd_valid2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy)
  );
  regfile_2r1w_clr #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2),
    .rd_addr2(rd_addr2), .rd_data1(nb_data1), .rd_data2(nb_data2), .rd_valid1(nb_valid1),
    .rd_valid2(nb_valid2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(nb_busy)
  );
  int n_checks = 0, n_pass = 0;
  logic [15:0] mem [16];
  logic [15:0] m_d1, m_d2;
  logic m_v1, m_v2, m_busy;
  int m_left;
  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    m_d1 = 0; m_d2 = 0; m_v1 = 0; m_v2 = 0; m_busy = 0; m_left = 0;
  endtask
  // drive one cycle of stimulus (called at a negedge), advance the model, return at the next negedge
  task automatic cycle(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic r1, input logic [3:0] a1, input logic r2, input logic [3:0] a2,
                       input logic cr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en1 = r1; rd_addr1 = a1; rd_en2 = r2; rd_addr2 = a2; clr_req = cr;
    @(posedge clk);
    if (!m_busy) begin
      m_v1 = r1; m_v2 = r2;
      if (r1) m_d1 = (we && wa == a1) ? wd : mem[a1];
      if (r2) m_d2 = (we && wa == a2) ? wd : mem[a2];
      if (we) mem[wa] = wd;
      if (cr) begin m_busy = 1; m_left = 16; end
    end else begin
      m_v1 = 0; m_v2 = 0;
      mem[16 - m_left] = 16'h0;
      m_left--;
      if (m_left == 0) m_busy = 0;
    end
    @(negedge clk);
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    model_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if ({rd_data1, rd_data2, rd_valid1, rd_valid2, busy} !== 35'h0)
      $display("FAIL reset_outputs got d1=%h d2=%h v=%b%b busy=%b want all 0", rd_data1, rd_data2, rd_valid1, rd_valid2, busy);
    else n_pass++;
    rst_n = 1'b1;
    cycle(0, 0, 0, 1, 7, 1, 4, 0);
    n_checks++; if (rd_data1 !== 16'h0 || rd_valid1 !== 1'b1)
      $display("FAIL read1_after_reset got d=%h v=%b want 0000/1", rd_data1, rd_valid1);
    else n_pass++;
    n_checks++; if (rd_data2 !== 16'h0 || rd_valid2 !== 1'b1)
      $display("FAIL read2_after_reset got d=%h v=%b want 0000/1", rd_data2, rd_valid2);
    else n_pass++;
    idle();
    n_checks++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0)
      $display("FAIL valid_pulse got v1=%b v2=%b want 0/0", rd_valid1, rd_valid2);
    else n_pass++;
  endtask
  task automatic test_write_read();
    cycle(1, 10, 16'd20, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 10, 0, 0, 0);
    n_checks++; if (rd_data1 !== 16'h0014 || rd_valid1 !== 1'b1)
      $display("FAIL write_read got d=%h v=%b want 0014/1", rd_data1, rd_valid1);
    else n_pass++;
    n_checks++; if (rd_valid2 !== 1'b0)
      $display("FAIL valid2_idle got %b want 0", rd_valid2);
    else n_pass++;
  endtask
  task automatic test_bypass();
    cycle(1, 3, 16'hBEEF, 1, 3, 1, 3, 0);
    n_checks++; if (rd_data1 !== 16'hBEEF || rd_data2 !== 16'hBEEF)
      $display("FAIL bypass1 got d1=%h d2=%h want BEEF/BEEF", rd_data1, rd_data2);
    else n_pass++;
    n_checks++; if (nb_data1 !== 16'h0 || nb_data2 !== 16'h0)
      $display("FAIL nobypass_old got d1=%h d2=%h want 0000/0000", nb_data1, nb_data2);
    else n_pass++;
    cycle(0, 0, 0, 1, 3, 1, 3, 0);
    n_checks++; if (nb_data1 !== 16'hBEEF || nb_data2 !== 16'hBEEF)
      $display("FAIL nobypass_reread got d1=%h d2=%h want BEEF/BEEF", nb_data1, nb_data2);
    else n_pass++;
  endtask
  task automatic test_clear();
    int cnt = 1, guard = 0;
    logic bad_valid = 0;
    for (int i = 0; i < 16; i++) cycle(1, 4'(i), 16'(2 * i + 2), 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 15, 1, 0, 0);
    n_checks++; if (rd_data1 !== 16'd32 || rd_data2 !== 16'd2)
      $display("FAIL prefill got d1=%h d2=%h want 0020/0002", rd_data1, rd_data2);
    else n_pass++;
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (busy !== 1'b1)
      $display("FAIL busy_rise got %b want 1", busy);
    else n_pass++;
    while (busy === 1'b1 && guard < 40) begin
      cycle(1, 5, 16'h1234, 1, 5, 1, 5, 0);
      if (rd_valid1 || rd_valid2) bad_valid = 1;
      if (busy === 1'b1) cnt++;
      guard++;
    end
    n_checks++; if (cnt !== 16)
      $display("FAIL busy_length got %0d want 16", cnt);
    else n_pass++;
    n_checks++; if (bad_valid !== 1'b0)
      $display("FAIL valid_during_busy got 1 want 0");
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 1, 4'(i), 1, 4'(15 - i), 0);
      n_checks++; if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0 || rd_valid1 !== 1'b1)
        $display("FAIL cleared_%0d got d1=%h d2=%h v1=%b want 0000/0000/1", i, rd_data1, rd_data2, rd_valid1);
      else n_pass++;
    end
  endtask
  task automatic test_clr_with_write();
    int guard = 0;
    cycle(1, 9, 16'h00AA, 1, 9, 0, 0, 1);
    n_checks++; if (rd_data1 !== 16'h00AA || busy !== 1'b1)
      $display("FAIL clr_write_same got d1=%h busy=%b want 00AA/1", rd_data1, busy);
    else n_pass++;
    while (busy === 1'b1 && guard < 40) begin idle(); guard++; end
    cycle(0, 0, 0, 1, 9, 0, 0, 0);
    n_checks++; if (rd_data1 !== 16'h0 || busy !== 1'b0)
      $display("FAIL clr_write_after got d1=%h busy=%b want 0000/0", rd_data1, busy);
    else n_pass++;
  endtask
  task automatic test_reset_during_clear();
    cycle(1, 2, 16'h0077, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 1, 2, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) idle();
    n_checks++; if (busy !== 1'b1 || rd_data1 !== 16'h0077)
      $display("FAIL pre_abort got busy=%b d1=%h want 1/0077", busy, rd_data1);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || rd_data1 !== 16'h0 || rd_data2 !== 16'h0)
      $display("FAIL async_abort got busy=%b d1=%h d2=%h want 0/0000/0000", busy, rd_data1, rd_data2);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 2, 16'h0055, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 1, 8, 0);
    n_checks++; if (rd_data1 !== 16'h0055 || rd_data2 !== 16'h0 || busy !== 1'b0)
      $display("FAIL post_abort got d1=%h d2=%h busy=%b want 0055/0000/0", rd_data1, rd_data2, busy);
    else n_pass++;
  endtask
  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
            1'($urandom), 4'($urandom), ($urandom_range(0, 29) == 0));
      n_checks++;
      if (rd_data1 !== m_d1 || rd_data2 !== m_d2 || rd_valid1 !== m_v1 || rd_valid2 !== m_v2 || busy !== m_busy) begin
        if (errs < 10)
          $display("FAIL random_%0d got d1=%h d2=%h v=%b%b busy=%b want d1=%h d2=%h v=%b%b busy=%b",
                   n, rd_data1, rd_data2, rd_valid1, rd_valid2, busy, m_d1, m_d2, m_v1, m_v2, m_busy);
        errs++;
      end else n_pass++;
    end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_clr_with_write();
    test_reset_during_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
